// File: rtl/basic_i2s_receive.sv
// -----------------------------------------------------------------------------
// basic_i2s_receive
//   Philips-I2S receiver. The external SCK/WS/SD lines are oversampled in the
//   clk domain, each word is deserialised MSB first, and every completed
//   left/right pair is presented on a valid/ready output. clk must run at least
//   4x SCK (8x nominal).
//
// Parameters
//   DATA_WIDTH   bits per captured sample word (slot bits beyond this dropped)
//   SYNC_STAGES  flops per input synchroniser (>= 2)
//
// Ports
//   clk          system clock, all logic on rising edge
//   rst_n        synchronous reset, active low
//   sck, ws, sd  I2S bit clock, word select (0=left, 1=right), serial data
//   data_left    left sample of the presented pair
//   data_right   right sample of the presented pair
//   out_valid    pair valid, held until out_ready
//   out_ready    consumer accepts the pair when out_valid && out_ready
//   overrun      sticky flag: a completed pair was dropped (reset clears it)
//   len_err      one-clk pulse: a captured word's slot length != DATA_WIDTH
// -----------------------------------------------------------------------------
module basic_i2s_receive #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sd,
    output logic [DATA_WIDTH-1:0] data_left,
    output logic [DATA_WIDTH-1:0] data_right,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic                  len_err
);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] DW8 = 8'(DATA_WIDTH);

    genvar gi;

    // ------------------------------------------------------------------
    // Input synchronisers: {sck, ws, sd} travel together through the same
    // number of stages so the sampled ws/sd line up with the detected edge.
    // ------------------------------------------------------------------
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [2:0] stage_reg;
        if (gi == 0) begin : g_in
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= {sck, ws, sd};
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    end

    logic sck_s;
    logic ws_s;
    logic sd_s;
    assign sck_s = g_sync[SYNC_STAGES-1].stage_reg[2];
    assign ws_s  = g_sync[SYNC_STAGES-1].stage_reg[1];
    assign sd_s  = g_sync[SYNC_STAGES-1].stage_reg[0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_reg;
    state_t                  state_next;
    logic                    sck_prev_reg;
    logic                    ws_prev_reg;
    logic [7:0]              bit_cnt_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   left_hold_reg;
    logic                    left_ok_reg;
    logic [DATA_WIDTH-1:0]   data_left_reg;
    logic [DATA_WIDTH-1:0]   data_right_reg;
    logic                    out_valid_reg;
    logic                    overrun_reg;
    logic                    len_err_reg;

    logic                    sck_rise;
    logic                    boundary;
    logic [DATA_WIDTH-1:0]   bit_mask;
    logic [DATA_WIDTH-1:0]   word_cap;
    logic [7:0]              word_len;
    logic                    len_bad;
    logic                    capture_left;
    logic                    pair_done;
    logic                    load_out;

    assign sck_rise = sck_s & ~sck_prev_reg;
    // A change of WS seen at an SCK rise marks the LSB of the outgoing word.
    assign boundary = sck_rise & (ws_s != ws_prev_reg);

    // One-hot position for the current bit: bit index k lands at DATA_WIDTH-1-k,
    // so short words come out MSB-aligned and bits past DATA_WIDTH hit nothing.
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
        assign bit_mask[DATA_WIDTH-1-gi] = (bit_cnt_reg == 8'(gi));
    end

    // Unwritten positions are still zero, so OR-ing in the bit is enough.
    assign word_cap = shift_reg | (bit_mask & {DATA_WIDTH{sd_s}});
    assign word_len = (bit_cnt_reg == 8'hFF) ? 8'hFF : (bit_cnt_reg + 8'd1);
    assign len_bad  = (word_len != DW8);

    // ------------------------------------------------------------------
    // FSM next-state and per-boundary decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        capture_left = 1'b0;
        pair_done    = 1'b0;
        case (state_reg)
            ST_SYNC: begin
                if (boundary) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    if (!ws_prev_reg) begin
                        capture_left = 1'b1;
                    end else if (left_ok_reg) begin
                        pair_done = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_SYNC;
            end
        endcase
    end

    // A finished pair is loaded when the output slot is free or being freed
    // in this same clock; otherwise it is dropped.
    assign load_out = pair_done & (~out_valid_reg | out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_prev_reg   <= 1'b0;
            ws_prev_reg    <= 1'b0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            left_hold_reg  <= '0;
            left_ok_reg    <= 1'b0;
            data_left_reg  <= '0;
            data_right_reg <= '0;
            out_valid_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            len_err_reg    <= 1'b0;
        end else begin
            sck_prev_reg <= sck_s;
            if (sck_rise) begin
                ws_prev_reg <= ws_s;
            end

            if (boundary) begin
                shift_reg   <= '0;
                bit_cnt_reg <= '0;
            end else if (sck_rise && (state_reg == ST_RUN)) begin
                shift_reg   <= word_cap;
                bit_cnt_reg <= word_len;
            end

            if (capture_left) begin
                left_hold_reg <= word_cap;
                left_ok_reg   <= 1'b1;
            end else if (pair_done) begin
                left_ok_reg   <= 1'b0;
            end

            len_err_reg <= boundary && (state_reg == ST_RUN) && len_bad;

            if (load_out) begin
                data_left_reg  <= left_hold_reg;
                data_right_reg <= word_cap;
                out_valid_reg  <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg  <= 1'b0;
            end

            if (pair_done && !load_out) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign data_left  = data_left_reg;
    assign data_right = data_right_reg;
    assign out_valid  = out_valid_reg;
    assign overrun    = overrun_reg;
    assign len_err    = len_err_reg;

endmodule

// File: tb/tb_basic_i2s_receive.sv
// -----------------------------------------------------------------------------
// tb_basic_i2s_receive
//   Directed bench for basic_i2s_receive at clk = 8x SCK, DATA_WIDTH = 32.
//   An I2S source is modelled by tasks; a small monitor logs every accepted
//   pair and counts len_err cycles, and the directed steps compare these and
//   the live outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_basic_i2s_receive;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        ws = 1'b0;
    logic        sd = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] data_left;
    logic [31:0] data_right;
    logic        out_valid;
    logic        overrun;
    logic        len_err;

    int checks = 0;
    int failures = 0;

    logic [63:0] pair_q[$];
    int          len_err_cnt = 0;

    basic_i2s_receive #(
        .DATA_WIDTH (32),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck       (sck),
        .ws        (ws),
        .sd        (sd),
        .data_left (data_left),
        .data_right(data_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    // Monitor: sampled on the falling edge, these are the values the next
    // rising edge acts on.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            pair_q.push_back({data_left, data_right});
            $display("tb: pair accepted L=%08h R=%08h", data_left, data_right);
        end
        if (len_err) begin
            len_err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One SCK period = 8 clk; called and returns on a falling clk edge.
    task automatic send_bit(input logic w, input logic d);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic w, input logic [63:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            send_bit(w, v[i]);
        end
    endtask

    // WS leads the MSB by one SCK: the LSB goes out with the other channel's WS.
    task automatic send_word(input logic ch, input logic [63:0] v, input int n);
        send_bits(ch, v, n - 1, 1);
        send_bit(~ch, v[0]);
    endtask

    task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int n);
        send_word(1'b0, l, n);
        send_word(1'b1, r, n);
    endtask

    // out_ready changes just after a rising edge so the monitor never races it.
    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_left"},  64'(data_left),  64'h0);
        check({tag, "_data_right"}, 64'(data_right), 64'h0);
        check({tag, "_out_valid"},  64'(out_valid),  64'h0);
        check({tag, "_overrun"},    64'(overrun),    64'h0);
        check({tag, "_len_err"},    64'(len_err),    64'h0);
    endtask

    initial begin
        int base;
        int lb;

        @(negedge clk);

        // ---------------- 1: nominal stream, ready always high -------------
        do_reset();
        check_outputs_zero("reset");
        send_frame(64'hA5A50001, 64'h5A5A8000, 32);   // sync frame, no pair
        base = pair_q.size();
        lb   = len_err_cnt;
        for (int k = 0; k < 3; k++) begin
            send_frame(64'hA5A50001, 64'h5A5A8000, 32);
        end
        repeat (2) @(negedge clk);
        check("t1_pairs", 64'(pair_q.size() - base), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t1_pair%0d", k), pair_q[base + k], 64'hA5A50001_5A5A8000);
        end
        check("t1_len_err", 64'(len_err_cnt - lb), 64'd0);
        check("t1_overrun", 64'(overrun), 64'd0);

        // ---------------- 2: back-pressure and overrun ---------------------
        set_ready(1'b0);
        base = pair_q.size();
        send_frame(64'h00001111, 64'h00002222, 32);
        check("t2_valid_f1", 64'(out_valid), 64'd1);
        check("t2_pair_f1", {data_left, data_right}, 64'h00001111_00002222);
        check("t2_overrun_f1", 64'(overrun), 64'd0);
        send_frame(64'h00003333, 64'h00004444, 32);
        check("t2_overrun_f2", 64'(overrun), 64'd1);
        check("t2_hold_f2", {data_left, data_right}, 64'h00001111_00002222);
        send_frame(64'h00005555, 64'h00006666, 32);
        check("t2_hold_f3", {data_left, data_right}, 64'h00001111_00002222);
        check("t2_none_taken", 64'(pair_q.size() - base), 64'd0);
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        check("t2_accept_cnt", 64'(pair_q.size() - base), 64'd1);
        check("t2_accept_pair", pair_q[base], 64'h00001111_00002222);
        check("t2_valid_low", 64'(out_valid), 64'd0);
        send_frame(64'h00007777, 64'h00008888, 32);
        repeat (2) @(negedge clk);
        check("t2_f4_cnt", 64'(pair_q.size() - base), 64'd2);
        check("t2_f4_pair", pair_q[base + 1], 64'h00007777_00008888);
        check("t2_overrun_sticky", 64'(overrun), 64'd1);

        // ---------------- 3: 24-bit slots ---------------------------------
        do_reset();
        check("t3_overrun_clr", 64'(overrun), 64'd0);
        send_frame(64'hABCDEF, 64'h123456, 24);
        base = pair_q.size();
        lb   = len_err_cnt;
        send_frame(64'hABCDEF, 64'h123456, 24);
        send_frame(64'hABCDEF, 64'h123456, 24);
        repeat (2) @(negedge clk);
        check("t3_pairs", 64'(pair_q.size() - base), 64'd2);
        check("t3_pair0", pair_q[base], 64'hABCDEF00_12345600);
        check("t3_pair1", pair_q[base + 1], 64'hABCDEF00_12345600);
        check("t3_len_err", 64'(len_err_cnt - lb), 64'd4);

        // ---------------- 4: 40-bit slots ---------------------------------
        do_reset();
        send_frame(64'hDEADBEEFA5, 64'hCAFEF00D3C, 40);
        base = pair_q.size();
        lb   = len_err_cnt;
        send_frame(64'hDEADBEEFA5, 64'hCAFEF00D3C, 40);
        repeat (2) @(negedge clk);
        check("t4_pairs", 64'(pair_q.size() - base), 64'd1);
        check("t4_pair", pair_q[base], 64'hDEADBEEF_CAFEF00D);
        check("t4_len_err", 64'(len_err_cnt - lb), 64'd2);

        // ---------------- 5: reset released mid right slot ----------------
        rst_n = 1'b0;
        send_word(1'b0, 64'h0BADF00D, 32);
        send_bits(1'b1, 64'h13572468, 31, 16);
        rst_n = 1'b1;
        base = pair_q.size();
        send_bits(1'b1, 64'h13572468, 15, 1);
        send_bit(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("t5_partial_dropped", 64'(pair_q.size() - base), 64'd0);
        send_frame(64'h2468ACE0, 64'h13579BDF, 32);
        repeat (2) @(negedge clk);
        check("t5_pairs", 64'(pair_q.size() - base), 64'd1);
        check("t5_first_pair", pair_q[base], 64'h2468ACE0_13579BDF);

        // ---------------- 6: reset mid left word with pair pending --------
        set_ready(1'b0);
        send_frame(64'h01234567, 64'h89ABCDEF, 32);
        send_frame(64'h76543210, 64'hFEDCBA98, 32);
        check("t6_valid_before", 64'(out_valid), 64'd1);
        check("t6_overrun_before", 64'(overrun), 64'd1);
        send_bits(1'b0, 64'h55AA55AA, 31, 16);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("t6_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_ready(1'b1);
        send_bits(1'b0, 64'h55AA55AA, 15, 1);
        send_bit(1'b1, 1'b0);
        send_word(1'b1, 64'hAA55AA55, 32);
        base = pair_q.size();
        send_frame(64'hC0FFEE01, 64'hFACE0002, 32);
        send_frame(64'h80000001, 64'h7FFFFFFE, 32);
        repeat (2) @(negedge clk);
        check("t6_pairs", 64'(pair_q.size() - base), 64'd2);
        check("t6_pair0", pair_q[base], 64'hC0FFEE01_FACE0002);
        check("t6_pair1", pair_q[base + 1], 64'h80000001_7FFFFFFE);
        check("t6_overrun", 64'(overrun), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
